mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified instruction/data memory between the pipeline fetch stage (I-port, read-only)
//  and the memory stage (D-port, load/store). One outstanding transaction at a time.
//  Generates fetch/memory stall requests for the hazard logic.
//  Supports fetch kill on taken branch/jump (PCSrc_E) and a response watchdog.
// PARAMETERS
//  AW          32   address width (bytes)
//  DW          32   data width
//  MAX_DSTREAK 4    max consecutive D grants while I is pending before I is forced
//  TIMEOUT     64   cycles in WAIT without mem_rvalid before abort
// PORTS
//  clk         in   1    single clock, all state on posedge
//  rst         in   1    synchronous, active-high reset
//  i_req       in   1    fetch request; held with i_addr until i_ack
//  i_addr      in   AW   fetch byte address
//  i_kill      in   1    taken branch/jump in EX: discard current/queued fetch
//  i_ack       out  1    1-cycle pulse, i_rdata valid
//  i_rdata     out  DW   fetched instruction (registered)
//  d_req       in   1    data request; held with d_we/d_addr/d_wdata/d_be until d_ack
//  d_we        in   1    1 = store, 0 = load
//  d_addr      in   AW   data byte address
//  d_wdata     in   DW   store data
//  d_be        in   DW/8 byte enables
//  d_ack       out  1    1-cycle pulse; d_rdata valid for loads
//  d_rdata     out  DW   load data (registered)
//  stall_F     out  1    i_req & ~i_ack
//  stall_M     out  1    d_req & ~d_ack
//  err         out  1    1-cycle pulse on watchdog timeout
//  mem_req     out  1    request to memory, held until mem_gnt
//  mem_we      out  1    write enable
//  mem_addr    out  AW   word-aligned address ({addr[AW-1:2],2'b00})
//  mem_wdata   out  DW   write data
//  mem_be      out  DW/8 byte enables (all ones for fetch)
//  mem_gnt     in   1    memory accepted request this cycle
//  mem_rvalid  in   1    response pulse (loads and stores); never in same cycle as gnt
//  mem_rdata   in   DW   read data, valid with mem_rvalid
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, streak=0, watchdog=0. Reset mid-transaction aborts it silently,
//   with no ack; a late mem_rvalid in IDLE is ignored.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE: pick owner and latch request fields. D wins, unless I is pending and streak==MAX_DSTREAK.
//    A D grant while I is pending increments streak; an I grant clears it.
//    i_req with i_kill in the same cycle is not granted.
//   ISSUE: mem_req=1 with latched fields until mem_gnt -> WAIT.
//   WAIT: on mem_rvalid, register mem_rdata -> RESP.
//    Watchdog counts cycles in WAIT; at TIMEOUT, err pulses -> IDLE with no ack.
//   RESP: pulse i_ack or d_ack for the owner -> IDLE.
//  Min latency: req seen cycle N; mem_req N+1; gnt N+1; rvalid >= N+2; ack N+3.
//  Kill: i_kill while owner=I in ISSUE/WAIT sets killed flag.
//   The transaction still completes on the memory side, but RESP emits no i_ack.
//   i_kill in RESP suppresses that cycle's i_ack.
//  Stores: d_ack on the rvalid response; d_rdata is don't-care.
//  Fields latched in IDLE; requester changes while owned are ignored.
// STRUCTURE
//  Package mem_arb_pkg: arb_state_e {IDLE,ISSUE,WAIT,RESP}, owner_e {OWN_I,OWN_D}.
//  Sub-module arb_streak_ctr: saturating D-streak counter with clear/inc/at_max outputs.
//  Watchdog counter and FSM stay in top.
// TESTING
//  1 Lone fetch i_addr=0x10, gnt same cycle, rvalid 1 later, rdata=0x00500093
//    -> i_ack at N+3, i_rdata=0x00500093, mem_be=4'hF.
//  2 i_req and d_req (load 0x100) both high
//    -> D granted first, d_ack, then I granted; stall_F high throughout.
//  3 d_req held high for 10 txns with i_req pending, MAX_DSTREAK=4
//    -> grant order D,D,D,D,I,D...; I never waits more than 4 D txns.
//  4 i_kill pulsed in WAIT of a fetch
//    -> mem txn completes, no i_ack, FSM IDLE; new fetch at target accepted next.
//  5 mem_rvalid withheld, TIMEOUT=64
//    -> err pulse after 64 WAIT cycles, no ack, state IDLE.
//  6 rst asserted in WAIT, late mem_rvalid after release
//    -> all outputs 0, rvalid ignored, no ack.
//    Store d_addr=0x203, d_be=4'b1000 -> mem_addr=0x200, mem_we=1, d_ack on rvalid.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
//
// Contents:
//   arb_state_e  arbiter FSM states (IDLE -> ISSUE -> WAIT -> RESP)
//   owner_e      which requester owns the in-flight memory transaction
//   is_busy()    true while a transaction is on the memory side (ISSUE/WAIT)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // A fetch kill only marks the transaction while it is still outstanding
  // at the memory; in RESP the kill acts directly on that cycle's ack.
  function automatic logic is_busy(input arb_state_e s);
    return (s == ISSUE) || (s == WAIT);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_streak_ctr.sv
// Saturating counter of consecutive D-port grants made while a fetch was
// waiting. Once it reaches MAX the arbiter must hand the memory to the
// fetch port, which clears the count.
//
// Ports:
//   clk     clock, all state on posedge
//   rst     synchronous active-high reset
//   clear   clear the streak (fetch granted)
//   inc     count one more D grant over a pending fetch
//   at_max  streak has reached MAX
module arb_streak_ctr #(
  parameter int MAX = 4,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic at_max
);

  logic [CW-1:0] count_q;

  // Clear has priority over increment; the count never wraps past MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc && !at_max) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign at_max = (count_q == CW'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port unified memory between the fetch stage
// (I-port, read-only) and the memory stage (D-port, load/store). One memory
// transaction is outstanding at a time. D requests normally win, but after
// MAX_DSTREAK consecutive D grants over a waiting fetch the fetch is forced.
// A taken branch (i_kill) discards the in-flight or same-cycle fetch, and a
// watchdog aborts a transaction whose response never arrives.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   i_req/i_addr/i_kill          fetch request, address, fetch kill
//   i_ack/i_rdata                fetch completion pulse and instruction
//   d_req/d_we/d_addr/d_wdata/d_be  data request and its fields
//   d_ack/d_rdata                data completion pulse and load data
//   stall_F/stall_M              stall requests for the hazard unit
//   err                          pulse on watchdog abort
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be  request to the memory
//   mem_gnt/mem_rvalid/mem_rdata              memory accept and response
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  input  logic            i_kill,
  output logic            i_ack,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_ack,
  output logic [DW-1:0]   d_rdata,
  output logic            stall_F,
  output logic            stall_M,
  output logic            err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int BW  = DW / 8;
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);

  arb_state_e     state_q, state_d;
  owner_e         owner_q;
  logic           we_q;
  logic [AW-1:0]  addr_q;
  logic [DW-1:0]  wdata_q;
  logic [BW-1:0]  be_q;
  logic           killed_q;
  logic [DW-1:0]  rdata_q;
  logic [WDW-1:0] wd_q;

  logic fetch_ok;
  logic grant_i;
  logic grant_d;
  logic streak_clr;
  logic streak_inc;
  logic streak_at_max;
  logic timeout;

  arb_streak_ctr #(
    .MAX (MAX_DSTREAK)
  ) u_streak (
    .clk    (clk),
    .rst    (rst),
    .clear  (streak_clr),
    .inc    (streak_inc),
    .at_max (streak_at_max)
  );

  // A fetch that is being killed in the same cycle is stale and never
  // competes for the memory.
  assign fetch_ok = i_req & ~i_kill;

  // Next-state logic and grant decision. In IDLE the D-port wins unless a
  // live fetch has already been passed over MAX_DSTREAK times in a row.
  always_comb begin
    state_d    = state_q;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    streak_clr = 1'b0;
    streak_inc = 1'b0;
    timeout    = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req && !(fetch_ok && streak_at_max)) begin
          grant_d    = 1'b1;
          streak_inc = fetch_ok;
          state_d    = ISSUE;
        end else if (fetch_ok) begin
          grant_i    = 1'b1;
          streak_clr = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d = RESP;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register plus the transaction fields, which are captured only at
  // grant so requester changes during ownership have no effect. Fetches are
  // always full-word reads. The watchdog restarts every time WAIT is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_I;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      killed_q <= 1'b0;
      rdata_q  <= '0;
      wd_q     <= '0;
    end else begin
      state_q <= state_d;
      if (grant_i) begin
        owner_q  <= OWN_I;
        we_q     <= 1'b0;
        addr_q   <= i_addr & ALIGN_MASK;
        wdata_q  <= '0;
        be_q     <= '1;
        killed_q <= 1'b0;
      end else if (grant_d) begin
        owner_q  <= OWN_D;
        we_q     <= d_we;
        addr_q   <= d_addr & ALIGN_MASK;
        wdata_q  <= d_wdata;
        be_q     <= d_be;
        killed_q <= 1'b0;
      end else if (is_busy(state_q) && owner_q == OWN_I && i_kill) begin
        killed_q <= 1'b1;
      end
      if (state_q == WAIT && mem_rvalid) begin
        rdata_q <= mem_rdata;
      end
      if (state_q == WAIT) begin
        wd_q <= wd_q + WDW'(1);
      end else begin
        wd_q <= '0;
      end
    end
  end

  // Outputs decode from the registered state; a killed fetch, or a kill
  // arriving in the RESP cycle itself, swallows the fetch ack.
  always_comb begin
    mem_req   = (state_q == ISSUE);
    mem_we    = (state_q == ISSUE) & we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_be    = be_q;
    i_ack     = (state_q == RESP) & (owner_q == OWN_I) & ~killed_q & ~i_kill;
    d_ack     = (state_q == RESP) & (owner_q == OWN_D);
    err       = timeout;
    i_rdata   = rdata_q;
    d_rdata   = rdata_q;
    stall_F   = i_req & ~i_ack;
    stall_M   = d_req & ~d_ack;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a behavioural memory responds to
// the arbiter, and each scenario task compares the DUT against expectations
// built from a reference memory and the arbitration rules.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_kill;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        stall_F;
  logic        stall_M;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt    = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata  = 32'h0;

  int total = 0;
  int bad   = 0;

  int cfg_gnt      = 0;
  int cfg_rv       = 0;
  bit cfg_random   = 1'b0;
  bit cfg_withhold = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } gnt_t;

  gnt_t        gnt_log[$];
  logic [31:0] mem_arr[logic [31:0]];
  logic [31:0] ref_arr[logic [31:0]];

  bit          rv_pending = 1'b0;
  int          rv_cnt     = 0;
  int          g_cnt      = 0;
  logic [31:0] pend_data  = 32'h0;

  mem_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_kill     (i_kill),
    .i_ack      (i_ack),
    .i_rdata    (i_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_be       (d_be),
    .d_ack      (d_ack),
    .d_rdata    (d_rdata),
    .stall_F    (stall_F),
    .stall_M    (stall_M),
    .err        (err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Power-on memory contents: a known instruction at 0x10, a hash elsewhere.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h10) return 32'h0050_0093;
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return ref_arr.exists(w) ? ref_arr[w] : init_word(w);
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    ref_arr[w] = merge_be(ref_read(w), wd, be);
  endtask

  // Behavioural memory: grants after a configurable delay, accesses the
  // array at grant, and answers with rvalid at least one cycle later.
  always begin : mem_model
    logic [31:0] w;
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (rv_pending) begin
      if (rv_cnt == 0) begin
        rv_pending = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = pend_data;
      end else begin
        rv_cnt--;
      end
    end else if (mem_req === 1'b1) begin
      if (g_cnt == 0) begin
        mem_gnt = 1'b1;
        w = mem_addr;
        gnt_log.push_back('{addr: mem_addr, we: mem_we, be: mem_be, wdata: mem_wdata});
        if (mem_we) begin
          mem_arr[w] = merge_be(mem_arr.exists(w) ? mem_arr[w] : init_word(w), mem_wdata, mem_be);
          pend_data  = 32'h0;
        end else begin
          pend_data = mem_arr.exists(w) ? mem_arr[w] : init_word(w);
        end
        rv_pending = !cfg_withhold;
        rv_cnt     = cfg_random ? int'($urandom_range(0, 3)) : cfg_rv;
        g_cnt      = cfg_random ? int'($urandom_range(0, 2)) : cfg_gnt;
      end else begin
        g_cnt--;
      end
    end else begin
      g_cnt = cfg_random ? int'($urandom_range(0, 2)) : cfg_gnt;
    end
  end

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; i_req = 1'b0; i_kill = 1'b0; d_req = 1'b0; d_we = 1'b0;
    cfg_random = 1'b0; cfg_withhold = 1'b0; cfg_gnt = 0; cfg_rv = 0;
    repeat (8) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
    total++; if (mem_be !== 4'h0) begin bad++; $display("[TB] FAIL reset_mem_be: got %h expected 0", mem_be); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    total++; if ({i_ack, d_ack, err} !== 3'b000) begin bad++; $display("[TB] FAIL reset_pulses: got %b expected 000", {i_ack, d_ack, err}); end
    total++; if (i_rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata: got %h expected 0", i_rdata); end
    total++; if ({stall_F, stall_M} !== 2'b00) begin bad++; $display("[TB] FAIL reset_stalls: got %b expected 00", {stall_F, stall_M}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL idle_mem_req: got %b expected 0", mem_req); end
  endtask

  task automatic test_lone_fetch;
    do_reset;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    total++; if (mem_req !== 1'b1) begin bad++; $display("[TB] FAIL fetch_mem_req: got %b expected 1", mem_req); end
    total++; if (mem_be !== 4'hF) begin bad++; $display("[TB] FAIL fetch_mem_be: got %h expected f", mem_be); end
    total++; if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin bad++; $display("[TB] FAIL fetch_addr_we: got %h/%b expected 00000010/0", mem_addr, mem_we); end
    total++; if (stall_F !== 1'b1 || i_ack !== 1'b0) begin bad++; $display("[TB] FAIL fetch_stall_n1: got %b/%b expected 1/0", stall_F, i_ack); end
    @(negedge clk);
    total++; if (i_ack !== 1'b0) begin bad++; $display("[TB] FAIL fetch_early_ack: got %b expected 0", i_ack); end
    @(negedge clk);
    total++; if (i_ack !== 1'b1) begin bad++; $display("[TB] FAIL fetch_ack_n3: got %b expected 1", i_ack); end
    total++; if (i_rdata !== 32'h0050_0093) begin bad++; $display("[TB] FAIL fetch_rdata: got %h expected 00500093", i_rdata); end
    i_req = 1'b0;
    @(negedge clk);
    total++; if (i_ack !== 1'b0) begin bad++; $display("[TB] FAIL fetch_ack_pulse: got %b expected 0", i_ack); end
  endtask

  task automatic test_both_pending;
    int  base, first_d, first_i;
    bit  stall_ok;
    do_reset;
    cfg_rv = 1;
    base = gnt_log.size();
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF; d_wdata = 32'h0;
    first_d = -1; first_i = -1; stall_ok = 1'b1;
    for (int c = 1; c <= 40 && first_i < 0; c++) begin
      @(negedge clk);
      if (i_ack !== 1'b1 && stall_F !== 1'b1) stall_ok = 1'b0;
      if (d_ack === 1'b1 && first_d < 0) begin
        first_d = c;
        total++; if (d_rdata !== ref_read(32'h100)) begin bad++; $display("[TB] FAIL both_d_rdata: got %h expected %h", d_rdata, ref_read(32'h100)); end
        d_req = 1'b0;
      end
      if (i_ack === 1'b1) begin
        first_i = c;
        total++; if (i_rdata !== ref_read(32'h40)) begin bad++; $display("[TB] FAIL both_i_rdata: got %h expected %h", i_rdata, ref_read(32'h40)); end
        i_req = 1'b0;
      end
    end
    total++; if (!(first_d > 0 && first_i > first_d)) begin bad++; $display("[TB] FAIL both_order: got d_ack@%0d i_ack@%0d expected d before i", first_d, first_i); end
    total++; if (!stall_ok) begin bad++; $display("[TB] FAIL both_stall_F: got a low cycle expected high until i_ack"); end
    total++;
    if (gnt_log.size() - base < 2 || gnt_log[base].addr !== 32'h100 || gnt_log[base+1].addr !== 32'h40) begin
      bad++; $display("[TB] FAIL both_grant_log: got %0d grants expected 0x100 then 0x40", gnt_log.size() - base);
    end
  endtask

  task automatic new_fetch(output logic [31:0] exp);
    i_addr = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
    exp = ref_read(i_addr);
  endtask

  task automatic new_data(output logic [31:0] exp);
    d_we    = 1'($urandom_range(0, 1));
    d_addr  = 32'h2000 + 32'($urandom_range(0, 31));
    d_be    = 4'($urandom_range(1, 15));
    d_wdata = $urandom;
    exp     = ref_read(d_addr);
    if (d_we) ref_write(d_addr, d_wdata, d_be);
  endtask

  task automatic test_streak;
    int          base, d_done, dcnt;
    logic [31:0] exp_i, exp_d;
    bit          exp_d_owner, got_d_owner;
    do_reset;
    cfg_random = 1'b1;
    base = gnt_log.size();
    d_done = 0;
    @(negedge clk);
    new_fetch(exp_i);
    new_data(exp_d);
    i_req = 1'b1; d_req = 1'b1;
    for (int c = 0; c < 600 && d_done < 10; c++) begin
      @(negedge clk);
      if (d_ack === 1'b1) begin
        if (!d_we) begin
          total++; if (d_rdata !== exp_d) begin bad++; $display("[TB] FAIL streak_load_data: got %h expected %h", d_rdata, exp_d); end
        end
        d_done++;
        if (d_done < 10) new_data(exp_d);
        else d_req = 1'b0;
      end
      if (i_ack === 1'b1) begin
        total++; if (i_rdata !== exp_i) begin bad++; $display("[TB] FAIL streak_fetch_data: got %h expected %h", i_rdata, exp_i); end
        new_fetch(exp_i);
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    total++; if (d_done != 10) begin bad++; $display("[TB] FAIL streak_d_count: got %0d expected 10", d_done); end
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      exp_d_owner = (dcnt != 4);
      dcnt = exp_d_owner ? dcnt + 1 : 0;
      got_d_owner = (base + k < gnt_log.size()) ? gnt_log[base+k].addr[13] : ~exp_d_owner;
      total++;
      if (got_d_owner !== exp_d_owner) begin
        bad++; $display("[TB] FAIL streak_order[%0d]: got %s expected %s", k, got_d_owner ? "D" : "I", exp_d_owner ? "D" : "I");
      end
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_kill;
    int          base, acks, miss;
    logic [31:0] first_data;
    do_reset;
    cfg_rv = 3;
    base = gnt_log.size();
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h80;
    repeat (2) @(negedge clk);
    i_kill = 1'b1; i_addr = 32'h200;
    @(negedge clk);
    i_kill = 1'b0; cfg_rv = 0;
    acks = 0; first_data = 32'h0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (i_ack === 1'b1) begin
        if (acks == 0) first_data = i_rdata;
        acks++;
        i_req = 1'b0;
      end
    end
    total++; if (acks != 1) begin bad++; $display("[TB] FAIL kill_ack_count: got %0d expected 1", acks); end
    total++; if (first_data !== ref_read(32'h200)) begin bad++; $display("[TB] FAIL kill_target_data: got %h expected %h", first_data, ref_read(32'h200)); end
    total++;
    if (gnt_log.size() - base != 2 || gnt_log[base].addr !== 32'h80 || gnt_log[base+1].addr !== 32'h200) begin
      bad++; $display("[TB] FAIL kill_grant_log: got %0d grants expected 0x80 then 0x200", gnt_log.size() - base);
    end
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h400;
    repeat (3) @(negedge clk);
    i_kill = 1'b1; i_req = 1'b0;
    #1;
    total++; if (i_ack !== 1'b0) begin bad++; $display("[TB] FAIL kill_in_resp: got %b expected 0", i_ack); end
    @(negedge clk);
    i_kill = 1'b0;
    miss = 0;
    repeat (4) begin
      @(negedge clk);
      if (i_ack !== 1'b0) miss++;
    end
    total++; if (miss != 0) begin bad++; $display("[TB] FAIL kill_resp_late_ack: got %0d acks expected 0", miss); end
  endtask

  task automatic test_timeout;
    int errk, acks, reqs;
    do_reset;
    cfg_withhold = 1'b1;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_be = 4'hF;
    @(negedge clk);
    total++; if (mem_req !== 1'b1) begin bad++; $display("[TB] FAIL timeout_mem_req: got %b expected 1", mem_req); end
    errk = -1; acks = 0;
    for (int k = 1; k <= 100 && errk < 0; k++) begin
      @(negedge clk);
      if (d_ack === 1'b1) acks++;
      if (err === 1'b1) errk = k;
    end
    d_req = 1'b0; cfg_withhold = 1'b0;
    total++; if (errk != 64) begin bad++; $display("[TB] FAIL timeout_err_cycle: got %0d expected 64", errk); end
    @(negedge clk);
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL timeout_err_pulse: got %b expected 0", err); end
    reqs = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_req !== 1'b0) reqs++;
      if (d_ack === 1'b1) acks++;
    end
    total++; if (acks != 0 || reqs != 0) begin bad++; $display("[TB] FAIL timeout_idle: got acks=%0d reqs=%0d expected 0/0", acks, reqs); end
  endtask

  task automatic test_reset_abort_and_store;
    int          noise, done;
    logic [31:0] exp;
    do_reset;
    cfg_rv = 4;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h300;
    repeat (3) @(negedge clk);
    rst = 1'b1; i_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    total++; if ({mem_req, i_ack, d_ack, err} !== 4'b0000) begin bad++; $display("[TB] FAIL abort_outputs: got %b expected 0000", {mem_req, i_ack, d_ack, err}); end
    total++; if (i_rdata !== 32'h0) begin bad++; $display("[TB] FAIL abort_rdata: got %h expected 0", i_rdata); end
    noise = 0;
    repeat (8) begin
      @(negedge clk);
      if (i_ack !== 1'b0 || d_ack !== 1'b0 || mem_req !== 1'b0) noise++;
    end
    total++; if (noise != 0) begin bad++; $display("[TB] FAIL abort_late_rvalid: got %0d active cycles expected 0", noise); end
    cfg_rv = 0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h203; d_be = 4'b1000; d_wdata = 32'hAB00_0000;
    ref_write(32'h203, 32'hAB00_0000, 4'b1000);
    @(negedge clk);
    total++; if (mem_addr !== 32'h200 || mem_we !== 1'b1) begin bad++; $display("[TB] FAIL store_addr_we: got %h/%b expected 00000200/1", mem_addr, mem_we); end
    total++; if (mem_be !== 4'b1000 || mem_wdata !== 32'hAB00_0000) begin bad++; $display("[TB] FAIL store_be_data: got %h/%h expected 8/ab000000", mem_be, mem_wdata); end
    repeat (2) @(negedge clk);
    total++; if (d_ack !== 1'b1) begin bad++; $display("[TB] FAIL store_ack: got %b expected 1", d_ack); end
    d_req = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h201; d_be = 4'hF;
    exp = ref_read(32'h200);
    done = 0;
    for (int c = 0; c < 20 && done == 0; c++) begin
      @(negedge clk);
      if (d_ack === 1'b1) begin
        done = 1;
        total++; if (d_rdata !== exp) begin bad++; $display("[TB] FAIL store_readback: got %h expected %h", d_rdata, exp); end
      end
    end
    d_req = 1'b0;
    total++; if (done == 0) begin bad++; $display("[TB] FAIL store_readback_ack: got none expected d_ack within 20 cycles"); end
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; i_addr = 32'h0; i_kill = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    $display("[TB] starting mem_port_arbiter bench");
    test_reset;
    test_lone_fetch;
    test_both_pending;
    test_streak;
    test_kill;
    test_timeout;
    test_reset_abort_and_store;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
